// File: rtl/nibble_serial_sub_pkg.sv
// rtl/nibble_serial_sub_pkg.sv - shared constants and FSM encoding for the nibble-serial subtractor
package nibble_serial_sub_pkg;

    // Width of one datapath slice processed per clock.
    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_sub_slice4.sv
// rtl/nibble_serial_sub_slice4.sv - combinational 4-bit subtract slice with carry lookahead
//
// Computes diff = x - y - bin as x + ~y + ~bin.
// Ports:
//   x    in  4  minuend slice
//   y    in  4  subtrahend slice
//   bin  in  1  borrow into this slice
//   diff out 4  difference slice
//   bout out 1  borrow out of this slice (inverted carry out)
module nibble_serial_sub_slice4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic [3:0] yn;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign yn = ~y;
    assign p  = x ^ yn;
    assign g  = x & yn;

    // Carry-in of the adder form is the inverted borrow.
    assign c[0] = ~bin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign diff = p ^ c[3:0];
    assign bout = ~c[4];

endmodule

// File: rtl/nibble_serial_sub.sv
// rtl/nibble_serial_sub.sv - multi-cycle W-bit subtractor, one nibble per clock
//
// d = a - b - bin mod 2^W, computed one 4-bit slice per cycle with the borrow
// carried between cycles in a register. One operation in flight.
// Ports:
//   clk        in   1  clock, posedge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  operands valid
//   in_ready   out  1  block idle, operands accepted
//   a          in   W  minuend
//   b          in   W  subtrahend
//   bin        in   1  borrow in
//   out_valid  out  1  result valid
//   out_ready  in   1  consumer accepts result
//   d          out  W  difference
//   bout       out  1  borrow out (unsigned a < b + bin)
//   ovf        out  1  signed overflow
//   zero       out  1  d == 0
module nibble_serial_sub
    import nibble_serial_sub_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    localparam int N_SLICE = W / NIBBLE;
    localparam int IDX_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICE - 1);

    generate
        if ((W < NIBBLE) || ((W % NIBBLE) != 0)) begin : g_bad_width
            $error("nibble_serial_sub: W must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_e            state_q,  state_d;
    logic [W-1:0]      a_q,      a_d;
    logic [W-1:0]      b_q,      b_d;
    logic              borrow_q, borrow_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [W-1:0]      res_q,    res_d;
    logic              bout_q,   bout_d;
    logic              ovf_q,    ovf_d;
    logic              zero_q,   zero_d;

    logic [NIBBLE-1:0] sl_x;
    logic [NIBBLE-1:0] sl_y;
    logic [NIBBLE-1:0] sl_diff;
    logic              sl_bout;

    assign sl_x = a_q[NIBBLE*int'(idx_q) +: NIBBLE];
    assign sl_y = b_q[NIBBLE*int'(idx_q) +: NIBBLE];

    nibble_serial_sub_slice4 u_slice (
        .x    (sl_x),
        .y    (sl_y),
        .bin  (borrow_q),
        .diff (sl_diff),
        .bout (sl_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        res_d    = res_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    res_d    = '0;
                    bout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                res_d[NIBBLE*int'(idx_q) +: NIBBLE] = sl_diff;
                borrow_d = sl_bout;
                idx_d    = idx_q + 1'b1;
                // Flags are taken from the completed result so they are
                // registered together with the last slice.
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    bout_d  = sl_bout;
                    zero_d  = (res_d == '0);
                    ovf_d   = (a_q[W-1] != b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            res_q    <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            res_q    <= res_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign d         = res_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb/tb_nibble_serial_sub.sv - self-checking bench for nibble_serial_sub at W = 4, 16, 32
module tb_nibble_serial_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_bus = '0;
    logic [31:0] b_bus = '0;
    logic        bin_r = 1'b0;
    logic [2:0]  in_valid_v = '0;
    logic [2:0]  out_ready_v = '0;

    wire  [2:0]  in_ready_v;
    wire  [2:0]  out_valid_v;
    wire  [2:0]  bout_v;
    wire  [2:0]  ovf_v;
    wire  [2:0]  zero_v;
    wire  [3:0]  d4;
    wire  [15:0] d16;
    wire  [31:0] d32;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    nibble_serial_sub #(.W(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .bin(bin_r), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .d(d4), .bout(bout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
    );

    nibble_serial_sub #(.W(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .bin(bin_r), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .d(d16), .bout(bout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
    );

    nibble_serial_sub #(.W(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_bus), .b(b_bus), .bin(bin_r), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .d(d32), .bout(bout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] cur_d(input int sel);
        return (sel == 0) ? {28'b0, d4} : (sel == 1) ? {16'b0, d16} : d32;
    endfunction

    // Snapshot of all observable outputs of one instance, packed for a single compare.
    function automatic logic [63:0] snap(input int sel);
        return {27'b0, out_valid_v[sel], in_ready_v[sel], bout_v[sel], ovf_v[sel],
                zero_v[sel], cur_d(sel)};
    endfunction

    // Reference: plain integer arithmetic on the unsigned and signed views.
    task automatic model(input int wd, input logic [31:0] a, input logic [31:0] b, input logic bi,
                         output logic [31:0] d_e, output logic bo_e, output logic ov_e,
                         output logic z_e);
        longint m  = (64'sd1 <<< wd) - 1;
        longint ua = longint'(a) & m;
        longint ub = longint'(b) & m;
        longint half = 64'sd1 <<< (wd - 1);
        longint sa = (ua >= half) ? ua - (64'sd1 <<< wd) : ua;
        longint sb = (ub >= half) ? ub - (64'sd1 <<< wd) : ub;
        longint sd = sa - sb - longint'(bi);
        longint df = (ua - ub - longint'(bi)) & m;
        d_e  = df[31:0];
        bo_e = (ua < ub + longint'(bi));
        ov_e = (sd < -half) || (sd > half - 1);
        z_e  = (df == 0);
    endtask

    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic bi, input int hold);
        int wd = width_of(sel);
        int n = wd / 4;
        int t = 0;
        logic [31:0] d_e;
        logic bo_e, ov_e, z_e;
        logic [63:0] exp_snap;

        model(wd, a, b, bi, d_e, bo_e, ov_e, z_e);
        exp_snap = {27'b0, 1'b1, 1'b0, bo_e, ov_e, z_e, d_e};

        @(negedge clk);
        while (!in_ready_v[sel] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_v[sel]) check("in_ready_timeout", 64'(in_ready_v[sel]), 64'd1);

        a_bus = a;
        b_bus = b;
        bin_r = bi;
        in_valid_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[sel] = 1'b0;
        a_bus = $urandom;
        b_bus = $urandom;
        bin_r = 1'($urandom);

        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        check("lat_early", {62'b0, out_valid_v[sel], in_ready_v[sel]}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid", 64'(out_valid_v[sel]), 64'd1);
        check("d", 64'(cur_d(sel)), 64'(d_e));
        check("bout", 64'(bout_v[sel]), 64'(bo_e));
        check("ovf", 64'(ovf_v[sel]), 64'(ov_e));
        check("zero", 64'(zero_v[sel]), 64'(z_e));
        check("busy_in_ready", 64'(in_ready_v[sel]), 64'd0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold", snap(sel), exp_snap);
        end

        out_ready_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[sel] = 1'b0;
        @(negedge clk);
        check("drop_valid", {62'b0, out_valid_v[sel], in_ready_v[sel]}, 64'd1);
    endtask

    initial begin
        logic seen_valid;
        int sel;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("reset_state", snap(s), {27'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'b0});
        end
        rst = 1'b0;

        run_op(1, 32'h1234, 32'h0234, 1'b0, 0);
        run_op(1, 32'h0000, 32'h0001, 1'b0, 0);
        run_op(1, 32'h8000, 32'h0001, 1'b0, 1);
        run_op(1, 32'h0005, 32'h0005, 1'b1, 0);
        run_op(1, 32'h8000, 32'h0000, 1'b1, 0);
        run_op(1, 32'hABCD, 32'h1111, 1'b1, 10);

        // Reset while the second-to-last... slice idx=2 is being processed.
        @(negedge clk);
        a_bus = 32'h4321;
        b_bus = 32'h1234;
        in_valid_v[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid_v[1]) seen_valid = 1'b1;
        end
        check("rst_no_valid", 64'(seen_valid), 64'd0);
        check("rst_idle", snap(1), {27'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'b0});
        run_op(1, 32'h0010, 32'h0010, 1'b0, 0);

        run_op(0, 32'h3, 32'h3, 1'b1, 0);
        run_op(0, 32'h8, 32'h1, 1'b0, 2);
        run_op(2, 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(2, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0);

        for (int i = 0; i < 90; i++) begin
            sel = i % 3;
            run_op(sel, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

endmodule
